// File: rtl/rr_input_port.sv
// rr_input_port: router input port sitting in front of the round-robin output arbiters.
// Buffers incoming flits, computes the XY route of each head flit, requests one output
// through a 3-bit next-hop code and dequeues one flit per grant from that output's arbiter.
//
// Ports:
//   clk             clock
//   reset           asynchronous active-low reset
//   flit_i          incoming flit; [FLIT_W-1:FLIT_W-2] is the flit type
//   flit_valid_i    push strobe, one flit per cycle
//   grant_i         per-arbiter grants {N,S,W,E,L}, bit4 = N
//   flit_o          FIFO head flit to the crossbar (don't-care while flit_valid_o = 0)
//   flit_valid_o    head valid and route locked
//   nexthop_addr_o  requested output: 000 none, 001 N, 010 S, 011 W, 100 E, 101 L
//   credit_o        one-cycle credit pulse per freed slot
//   packet_end_o    one-cycle pulse when a tail or single flit is dequeued
//   overflow_o      sticky: push while full without a pop
//   route_err_o     sticky: non-head flit while idle, or U-turn route
module rr_input_port #(
    parameter int unsigned FLIT_W  = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned COORD_W = 2,
    parameter int unsigned X_COORD = 0,
    parameter int unsigned Y_COORD = 0,
    parameter logic [2:0]  PORT_ID = 3'b001
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              flit_valid_i,
    input  logic [4:0]        grant_i,
    output logic [FLIT_W-1:0] flit_o,
    output logic              flit_valid_o,
    output logic [2:0]        nexthop_addr_o,
    output logic              credit_o,
    output logic              packet_end_o,
    output logic              overflow_o,
    output logic              route_err_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [COORD_W-1:0] MY_X = COORD_W'(X_COORD);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(Y_COORD);

    localparam logic [2:0] HOP_NONE = 3'b000;
    localparam logic [2:0] HOP_N    = 3'b001;
    localparam logic [2:0] HOP_S    = 3'b010;
    localparam logic [2:0] HOP_W    = 3'b011;
    localparam logic [2:0] HOP_E    = 3'b100;
    localparam logic [2:0] HOP_L    = 3'b101;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // FIFO storage and bookkeeping
    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;

    state_e            r_state;
    state_e            w_state_next;
    logic [2:0]        r_route;

    logic              r_credit;
    logic              r_packet_end;
    logic              r_overflow;
    logic              r_route_err;

    logic [FLIT_W-1:0]  w_head;
    logic [1:0]         w_type;
    logic [COORD_W-1:0] w_dest_x;
    logic [COORD_W-1:0] w_dest_y;
    logic               w_empty;
    logic               w_full;
    logic               w_head_like;
    logic               w_is_last;
    logic [2:0]         w_route_raw;
    logic [2:0]         w_route;
    logic               w_uturn;
    logic               w_grant_sel;
    logic               w_req_valid;
    logic               w_latch;
    logic               w_discard;
    logic               w_pop_active;
    logic               w_pop;
    logic               w_push;

    // Head decode
    assign w_head      = r_mem[r_rd_ptr];
    assign w_type      = w_head[FLIT_W-1:FLIT_W-2];
    assign w_dest_x    = w_head[2*COORD_W-1:COORD_W];
    assign w_dest_y    = w_head[COORD_W-1:0];
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == FULL_CNT);
    // Type bit 0 marks head (01) and single (11); bit 1 marks tail (10) and single (11).
    assign w_head_like = w_type[0];
    assign w_is_last   = w_type[1];

    // XY dimension-ordered route, X first
    always_comb begin
        w_route_raw = HOP_L;
        if (w_dest_x > MY_X) begin
            w_route_raw = HOP_E;
        end else if (w_dest_x < MY_X) begin
            w_route_raw = HOP_W;
        end else if (w_dest_y > MY_Y) begin
            w_route_raw = HOP_S;
        end else if (w_dest_y < MY_Y) begin
            w_route_raw = HOP_N;
        end
        // Sending a packet back where it came from would deadlock; deliver locally instead.
        w_uturn = (w_route_raw == PORT_ID);
        w_route = w_uturn ? HOP_L : w_route_raw;
    end

    // Only the grant from the arbiter we are requesting counts
    always_comb begin
        w_grant_sel = 1'b0;
        unique case (r_route)
            HOP_N:   w_grant_sel = grant_i[4];
            HOP_S:   w_grant_sel = grant_i[3];
            HOP_W:   w_grant_sel = grant_i[2];
            HOP_E:   w_grant_sel = grant_i[1];
            HOP_L:   w_grant_sel = grant_i[0];
            default: w_grant_sel = 1'b0;
        endcase
    end

    assign w_req_valid  = (r_state == StActive) && !w_empty;
    assign w_latch      = (r_state == StIdle) && !w_empty && w_head_like;
    assign w_discard    = (r_state == StIdle) && !w_empty && !w_head_like;
    assign w_pop_active = w_req_valid && w_grant_sel;
    assign w_pop        = w_pop_active || w_discard;
    // A full FIFO still accepts a push when a slot frees in the same cycle.
    assign w_push       = flit_valid_i && (!w_full || w_pop);

    // FSM: state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_latch) begin
                    w_state_next = StActive;
                end
            end
            StActive: begin
                if (w_pop_active && w_is_last) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // FSM: outputs; the request drops whenever the FIFO runs dry mid-packet
    always_comb begin
        flit_valid_o   = w_req_valid;
        nexthop_addr_o = w_req_valid ? r_route : HOP_NONE;
    end

    // Route latch, held for the whole packet
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_route <= HOP_NONE;
        end else if (w_latch) begin
            r_route <= w_route;
        end
    end

    // FIFO storage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= flit_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Registered pulses and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_credit     <= 1'b0;
            r_packet_end <= 1'b0;
            r_overflow   <= 1'b0;
            r_route_err  <= 1'b0;
        end else begin
            r_credit     <= w_pop;
            r_packet_end <= w_pop_active && w_is_last;
            if (flit_valid_i && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
            if (w_discard || (w_latch && w_uturn)) begin
                r_route_err <= 1'b1;
            end
        end
    end

    assign flit_o       = w_head;
    assign credit_o     = r_credit;
    assign packet_end_o = r_packet_end;
    assign overflow_o   = r_overflow;
    assign route_err_o  = r_route_err;

endmodule
